switch_bounce_emulator: RTL and testbench
=========================================

Name: switch_bounce_emulator

Overview:
Bench/stimulus-side source that emulates a mechanical push-button. A single-cycle `press` strobe becomes a realistic switch waveform: press bounce, stable hold, release bounce, stable low. It drives debouncer inputs in simulation and on-board self-test, and is the producing end of the button-to-debouncer interface.

Parameters:
BOUNCE_CYCLES, 16, clock edges spent in each bounce phase (press and release); legal range 2 to 2^CNT_WIDTH
HOLD_CYCLES, 200, clock edges the output is held stable high between the bounce phases; legal range 1 to 2^CNT_WIDTH
CNT_WIDTH, 8, width of the shared phase counter
LFSR_SEED, 8'hA5, reset value of the bounce LFSR; must be nonzero

Ports:
clk  input  1  system clock; all state changes on rising edge
rst  input  1  reset, asynchronous, active-high
press  input  1  single-cycle request to emulate one full press/release; sampled only in IDLE
o  output  1  emulated switch level (registered)
busy  output  1  high from acceptance of press until o has returned to a stable 0 (registered)

Behaviour:
- Reset, async on rst=1: state=IDLE, cnt=0, o=0, busy=0, lfsr=LFSR_SEED. Outputs are valid immediately, with no clock required.
- LFSR: 8-bit Galois, taps 8'hB8 (x^8+x^6+x^5+x^4+1). Shifts right every clock edge while out of reset, in every state. The bounce value is lfsr[0].
- States: IDLE(0), PRESS_BOUNCE(1), HOLD(2), RELEASE_BOUNCE(3).
- IDLE:
  - press=1 -> state<=PRESS_BOUNCE, cnt<=0, busy<=1, o unchanged (0).
  - press=0 -> no change.
- PRESS_BOUNCE:
  - cnt==BOUNCE_CYCLES-1 -> o<=1, cnt<=0, state<=HOLD.
  - Otherwise -> o<=bounce value, cnt<=cnt+1.
- HOLD:
  - o stays 1.
  - cnt==HOLD_CYCLES-1 -> cnt<=0, state<=RELEASE_BOUNCE.
  - Otherwise -> cnt<=cnt+1.
- RELEASE_BOUNCE:
  - cnt==BOUNCE_CYCLES-1 -> o<=0, cnt<=0, busy<=0, state<=IDLE.
  - Otherwise -> o<=bounce value, cnt<=cnt+1.
- Timing, press accepted at edge k:
  - Bounce values appear on o at edges k+1 .. k+BOUNCE_CYCLES-1.
  - o is forced to 1 at edge k+BOUNCE_CYCLES.
  - Release bounce starts at edge k+BOUNCE_CYCLES+HOLD_CYCLES+1.
  - busy falls at edge k+2*BOUNCE_CYCLES+HOLD_CYCLES.
  - busy is high for 2*BOUNCE_CYCLES+HOLD_CYCLES cycles (232 at defaults).
- press while busy=1 is ignored; it is neither queued nor counted.
- press asserted on the same edge that busy falls is ignored, because state is not yet IDLE. It is accepted on the next edge if still high.
- press held high continuously: a new sequence starts on the first edge after return to IDLE.
- Counter compare is an equality test, with no wrap. Parameters are sized so that cnt never exceeds 2^CNT_WIDTH-1.
- rst mid-sequence: immediate abort to reset values. o drops to 0 with no release bounce.

Optional Feature:
Macro SWITCH_EMU_LFSR_EN.
- Defined: bounce value = lfsr[0] (pseudo-random chatter), as described above.
- Not defined:
  - Bounce value = ~o, a deterministic toggle.
  - Press bounce from o=0 gives 1,0,1,... for BOUNCE_CYCLES-1 edges, then forced 1.
  - Release bounce from o=1 gives 0,1,0,..., then forced 0.
  - No LFSR register is synthesized, and LFSR_SEED is unused.

Test Plan:
1. Reset. rst=1 for 3 cycles, with press toggling -> o=0 and busy=0 throughout. After release of rst with press=0 for 10 cycles, o=0 and busy=0.
2. Nominal sequence, macro undefined, defaults. press pulse at edge k:
   - o = 1,0,1,...,1 (15 alternating values starting with 1) at k+1..k+15.
   - o=1 from k+16 to k+216 inclusive.
   - Toggles 0,1,...,0 at k+217..k+231; o=0 and busy=0 at k+232.
3. Busy lockout. Second press pulses at k+5, k+100 and k+231 -> exactly one sequence occurs and busy falls at k+232. A press at k+233 starts a new sequence (busy=1 at k+233).
4. Held press. press=1 continuously for 600 cycles -> back-to-back sequences. busy is low for exactly one cycle between sequences, and each sequence lasts 232 cycles.
5. Mid-operation reset. Assert rst at k+100, during HOLD -> o=0 and busy=0 immediately, without waiting for a clock edge. After rst drops, a press pulse starts a full 232-cycle sequence.
6. LFSR build (SWITCH_EMU_LFSR_EN defined), LFSR_SEED=8'hA5:
   - During bounce phases o matches a reference-model Galois LFSR (taps 8'hB8) bit 0 at each edge.
   - o=1 exactly at k+16, and o=0 with busy=0 at k+232.

Source files
------------

// File: rtl/switch_bounce_emulator_if.sv
// Button-to-debouncer link: press request in, emulated switch level and busy out.
// The master end is the emulator. The slave end is the requester or debouncer.
interface switch_bounce_emulator_if;
    logic press;
    logic o;
    logic busy;

    modport master (input press, output o, output busy);
    modport slave  (output press, input o, input busy);
endinterface

// File: rtl/switch_bounce_emulator.sv
// Push-button emulator: a press strobe becomes bounce/hold/bounce. Busy lasts 2*BOUNCE_CYCLES+HOLD_CYCLES cycles.
// No backpressure: a press is accepted only in IDLE and is otherwise dropped, never queued.
// SWITCH_EMU_LFSR_EN selects LFSR chatter; when undefined, the bounce phases toggle deterministically.
module switch_bounce_emulator #(
    parameter int unsigned BOUNCE_CYCLES = 16,
    parameter int unsigned HOLD_CYCLES   = 200,
    parameter int unsigned CNT_WIDTH     = 8,
    parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
    input  logic                      clk,
    input  logic                      rst,
    switch_bounce_emulator_if.master  btn
);

    typedef enum logic [1:0] {
        IDLE           = 2'd0,
        PRESS_BOUNCE   = 2'd1,
        HOLD           = 2'd2,
        RELEASE_BOUNCE = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] BOUNCE_LAST = CNT_WIDTH'(BOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] HOLD_LAST   = CNT_WIDTH'(HOLD_CYCLES - 1);

    if (BOUNCE_CYCLES < 2 || BOUNCE_CYCLES > 2**CNT_WIDTH ||
        HOLD_CYCLES < 1 || HOLD_CYCLES > 2**CNT_WIDTH || LFSR_SEED == 8'h00) begin : g_bad_params
        $error("switch_bounce_emulator: illegal parameter combination");
    end

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 o_q, o_d;
    logic                 busy_q, busy_d;
    logic                 bounce;

`ifdef SWITCH_EMU_LFSR_EN
    logic [7:0] lfsr_q;

    // Galois LFSR x^8+x^6+x^5+x^4+1. It free-runs in every state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= {1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? 8'hB8 : 8'h00);
        end
    end

    assign bounce = lfsr_q[0];
`else
    assign bounce = ~o_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            o_q     <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            o_q     <= o_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        o_d     = o_q;
        busy_d  = busy_q;
        case (state_q)
            IDLE: begin
                if (btn.press) begin
                    state_d = PRESS_BOUNCE;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            PRESS_BOUNCE: begin
                if (cnt_q == BOUNCE_LAST) begin
                    o_d     = 1'b1;
                    cnt_d   = '0;
                    state_d = HOLD;
                end else begin
                    o_d   = bounce;
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            HOLD: begin
                o_d = 1'b1;
                if (cnt_q == HOLD_LAST) begin
                    cnt_d   = '0;
                    state_d = RELEASE_BOUNCE;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            RELEASE_BOUNCE: begin
                if (cnt_q == BOUNCE_LAST) begin
                    o_d     = 1'b0;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    o_d   = bounce;
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign btn.o    = o_q;
    assign btn.busy = busy_q;

endmodule

// File: tb/tb_switch_bounce_emulator.sv
// Bench for switch_bounce_emulator: randomized press timing checked against a per-edge waveform model.
// The same bench covers the default build and the SWITCH_EMU_LFSR_EN build.
module tb_switch_bounce_emulator;

    localparam int BC    = 16;
    localparam int HC    = 200;
    localparam int TOTAL = 2*BC + HC;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    switch_bounce_emulator_if sw();

    switch_bounce_emulator #(
        .BOUNCE_CYCLES (BC),
        .HOLD_CYCLES   (HC),
        .CNT_WIDTH     (8),
        .LFSR_SEED     (8'hA5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .btn (sw.master)
    );

    always #5 clk = ~clk;

    // Reference chatter source: lfsr_used holds the value in force during the most recent edge.
    logic [7:0] lfsr_m, lfsr_used;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_m    <= 8'hA5;
            lfsr_used <= 8'hA5;
        end else begin
            lfsr_used <= lfsr_m;
            lfsr_m    <= (lfsr_m >> 1) ^ (lfsr_m[0] ? 8'hB8 : 8'h00);
        end
    end

    // Expected o at edge k+j. The press is accepted at edge k.
    function automatic logic exp_o(input int j);
        int m;
        if (j <= 0 || j >= TOTAL) return 1'b0;
        if (j < BC) begin
`ifdef SWITCH_EMU_LFSR_EN
            return lfsr_used[0];
`else
            return (j % 2) == 1;
`endif
        end
        if (j <= BC + HC) return 1'b1;
        m = j - (BC + HC);
`ifdef SWITCH_EMU_LFSR_EN
        return lfsr_used[0];
`else
        return (m % 2) == 0;
`endif
    endfunction

    // Follows one sequence from acceptance (j=0) through j=stop_at.
    // press is driven high for edge k+j+1 when pmask[j+1] is set or j+1 <= hold_last.
    task automatic follow_seq(input string tag, input int hold_last, input int stop_at,
                              input logic [TOTAL+1:0] pmask);
        logic eo, eb;
        for (int j = 0; j <= stop_at; j++) begin
            @(posedge clk);
            #1;
            eo = exp_o(j);
            eb = (j < TOTAL);
            total++;
            if (sw.o !== eo) begin
                bad++;
                $display("FAIL %s o j=%0d got=%b exp=%b", tag, j, sw.o, eo);
            end
            total++;
            if (sw.busy !== eb) begin
                bad++;
                $display("FAIL %s busy j=%0d got=%b exp=%b", tag, j, sw.busy, eb);
            end
            sw.press = pmask[j+1] || (j + 1 <= hold_last);
        end
    endtask

    task automatic idle_gap(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            total++;
            if (sw.o !== 1'b0 || sw.busy !== 1'b0) begin
                bad++;
                $display("FAIL idle o=%b busy=%b exp=0/0", sw.o, sw.busy);
            end
        end
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        sw.press = 1'b0;
        #1;
        total++;
        if (sw.o !== 1'b0 || sw.busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_async o=%b busy=%b exp=0/0", sw.o, sw.busy);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            sw.press = ~sw.press;
            total++;
            if (sw.o !== 1'b0 || sw.busy !== 1'b0) begin
                bad++;
                $display("FAIL reset_hold cyc=%0d o=%b busy=%b exp=0/0", i, sw.o, sw.busy);
            end
        end
        rst      = 1'b0;
        sw.press = 1'b0;
        idle_gap(10);
    endtask

    task automatic test_nominal();
        for (int n = 0; n < 3; n++) begin
            idle_gap($urandom_range(0, 7));
            sw.press = 1'b1;
            follow_seq("nominal", 0, TOTAL, '0);
        end
    endtask

    task automatic test_busy_lockout();
        logic [TOTAL+1:0] pm;
        pm = '0;
        pm[5]   = 1'b1;
        pm[100] = 1'b1;
        pm[$urandom_range(1, TOTAL-2)] = 1'b1;
        pm[231] = 1'b1;
        // A press on the edge that busy falls is ignored, so the held press is accepted one edge later.
        pm[232] = 1'b1;
        pm[233] = 1'b1;
        idle_gap($urandom_range(1, 5));
        sw.press = 1'b1;
        follow_seq("lockout", 0, TOTAL, pm);
        follow_seq("lockout_next", 0, TOTAL, '0);
    endtask

    task automatic test_held_press();
        idle_gap(2);
        sw.press = 1'b1;
        follow_seq("held1", TOTAL + 1, TOTAL, '0);
        follow_seq("held2", TOTAL + 1, TOTAL, '0);
        follow_seq("held3", 600 - 2*(TOTAL + 1), TOTAL, '0);
        idle_gap(3);
    endtask

    task automatic test_mid_reset();
        sw.press = 1'b1;
        follow_seq("midrst_pre", 0, 100, '0);
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (sw.o !== 1'b0) begin
            bad++;
            $display("FAIL midrst_async o got=%b exp=0", sw.o);
        end
        total++;
        if (sw.busy !== 1'b0) begin
            bad++;
            $display("FAIL midrst_async busy got=%b exp=0", sw.busy);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        idle_gap($urandom_range(1, 4));
        sw.press = 1'b1;
        follow_seq("midrst_post", 0, TOTAL, '0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_nominal();
        test_busy_lockout();
        test_held_press();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
